// File: rtl/debounce_channel.sv
// One debounced button channel: counts consecutive sample ticks that disagree
// with the accepted level and commits the new value after STABLE_TICKS of them.
module debounce_channel #(
    parameter int STABLE_TICKS = 10
) (
    input  logic clkin,
    input  logic rst,
    input  logic tick,
    input  logic samp,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clkin) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            if (tick) begin
                // Any agreeing sample restarts the run; the count clears on acceptance so it never wraps.
                if (samp == level) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    level <= samp;
                    cnt   <= '0;
                    press <= samp;
                    rel   <= ~samp;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/debounce_module.sv
// Multi-channel push-button debouncer: shared synchronisers, polarity and
// sample-tick edge detect feeding one debounce_channel per button.
module debounce_module #(
    parameter int WIDTH        = 4,
    parameter int STABLE_TICKS = 10,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             tick_clk,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    // Pin value of a released button; also the XOR mask that maps pins to pressed=1.
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] samp;
    logic             tick_d;
    logic             tick;

    always_ff @(posedge clkin) begin
        if (rst) begin
            sync_p0 <= IDLE;
            sync_p1 <= IDLE;
            tick_d  <= 1'b0;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
            tick_d  <= tick_clk;
        end
    end

    assign samp = sync_p1 ^ IDLE;
    assign tick = tick_clk & ~tick_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clkin(clkin),
            .rst  (rst),
            .tick (tick),
            .samp (samp[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i])
        );
    end

endmodule

// File: tb/tb_debounce_module.sv
// Bench for debounce_module: an active-high and an active-low instance run side
// by side against a tick-run reference model built from the acceptance rules.
module tb_debounce_module;

    localparam int ST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       tick_clk;
    logic [3:0] btn_a, btn_b;
    logic [3:0] lvl_a, prs_a, rel_a;
    logic [3:0] lvl_b, prs_b, rel_b;
    logic [23:0] dut_v;
    logic [23:0] mdl_v;

    debounce_module #(.WIDTH(4), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b0)) u_dut_a (
        .clkin(clk), .rst(rst), .tick_clk(tick_clk), .btn_in(btn_a),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a)
    );

    debounce_module #(.WIDTH(4), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b1)) u_dut_b (
        .clkin(clk), .rst(rst), .tick_clk(tick_clk), .btn_in(btn_b),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b)
    );

    assign dut_v = {lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b};

    int checks = 0;
    int passed = 0;
    int ph = 0;
    bit tick_run = 1'b1;

    // Reference model state: index 0 = active-high instance, 1 = active-low.
    logic [3:0] m_s0 [2];
    logic [3:0] m_s1 [2];
    logic [3:0] m_samp [2];
    logic [3:0] m_lvl [2];
    logic [3:0] m_prs [2];
    logic [3:0] m_rel [2];
    int         m_run [2][4];
    logic       m_tprev;
    logic       m_tick;

    task automatic model_update();
        logic [3:0] s;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_s0[d] = (d == 1) ? 4'hF : 4'h0;
                m_s1[d] = m_s0[d];
                m_samp[d] = 4'h0;
                m_lvl[d] = 4'h0;
                m_prs[d] = 4'h0;
                m_rel[d] = 4'h0;
                for (int c = 0; c < 4; c++) m_run[d][c] = 0;
            end
            m_tprev = 1'b0;
            m_tick  = 1'b0;
        end else begin
            m_tick  = tick_clk && !m_tprev;
            m_tprev = tick_clk;
            for (int d = 0; d < 2; d++) begin
                s = (d == 1) ? ~m_s1[d] : m_s1[d];
                m_samp[d] = s;
                m_prs[d] = 4'h0;
                m_rel[d] = 4'h0;
                if (m_tick) begin
                    for (int c = 0; c < 4; c++) begin
                        if (s[c] !== m_lvl[d][c]) begin
                            m_run[d][c]++;
                            if (m_run[d][c] == ST) begin
                                m_lvl[d][c] = s[c];
                                if (s[c]) m_prs[d][c] = 1'b1;
                                else      m_rel[d][c] = 1'b1;
                                m_run[d][c] = 0;
                            end
                        end else begin
                            m_run[d][c] = 0;
                        end
                    end
                end
                m_s1[d] = m_s0[d];
                m_s0[d] = (d == 1) ? btn_b : btn_a;
            end
        end
        mdl_v = {m_lvl[0], m_prs[0], m_rel[0], m_lvl[1], m_prs[1], m_rel[1]};
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (tick_run) begin
            ph = (ph + 1) % 10;
            tick_clk = (ph < 5);
        end
    endtask

    task automatic test_reset();
        int npress = 0;
        btn_a = 4'hF;
        btn_b = 4'hF;
        rst = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (dut_v !== 24'h0) $display("FAIL reset_outputs got %h need 000000", dut_v);
            else passed++;
        end
        rst = 1'b0;
        repeat (60) begin
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL reset_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
            if (prs_a == 4'hF) npress++;
        end
        checks++;
        if (npress != 1) $display("FAIL reset_press_count got %0d need 1", npress);
        else passed++;
        checks++;
        if (lvl_a !== 4'hF) $display("FAIL reset_level got %b need 1111", lvl_a);
        else passed++;
    endtask

    task automatic test_clean_press();
        int npress = 0;
        logic relany = 1'b0;
        rst = 1'b1;
        btn_a = 4'h0;
        btn_b = 4'hF;
        step();
        rst = 1'b0;
        btn_a = 4'b0001;
        repeat (60) begin
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL press_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
            if (prs_a == 4'b0001) npress++;
            relany |= |rel_a;
        end
        checks++;
        if (npress != 1) $display("FAIL press_pulse_count got %0d need 1", npress);
        else passed++;
        checks++;
        if (relany !== 1'b0) $display("FAIL press_no_release got %b need 0", relany);
        else passed++;
        checks++;
        if (lvl_a !== 4'b0001) $display("FAIL press_level got %b need 0001", lvl_a);
        else passed++;
    endtask

    task automatic test_bounce();
        int bad = 0;
        int npress = 0;
        for (int k = 0; k < 6; k++) begin
            btn_a[1] = ~btn_a[1];
            repeat (10) begin
                step();
                checks++;
                if (dut_v !== mdl_v) $display("FAIL bounce_model t=%0t got %h need %h", $time, dut_v, mdl_v);
                else passed++;
                if (lvl_a[1] | prs_a[1] | rel_a[1]) bad++;
            end
        end
        checks++;
        if (bad != 0) $display("FAIL bounce_quiet got %0d active cycles need 0", bad);
        else passed++;
        btn_a[1] = 1'b1;
        repeat (60) begin
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL bounce_hold_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
            if (prs_a[1]) npress++;
        end
        checks++;
        if (npress != 1 || lvl_a !== 4'b0011)
            $display("FAIL bounce_accept got presses=%0d level=%b need 1 and 0011", npress, lvl_a);
        else passed++;
    endtask

    task automatic test_simultaneous();
        logic both = 1'b0;
        btn_a = 4'b0001;
        repeat (60) begin
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL simul_setup_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
        end
        checks++;
        if (lvl_a !== 4'b0001) $display("FAIL simul_setup_level got %b need 0001", lvl_a);
        else passed++;
        btn_a = 4'b0100;
        repeat (60) begin
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL simul_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
            if (prs_a == 4'b0100 && rel_a == 4'b0001) both = 1'b1;
        end
        checks++;
        if (!both) $display("FAIL simul_same_cycle got %b need 1", both);
        else passed++;
        checks++;
        if (lvl_a !== 4'b0100) $display("FAIL simul_level got %b need 0100", lvl_a);
        else passed++;
    endtask

    task automatic test_reset_midcount_and_freeze();
        int waited = 0;
        int q = 0;
        int q_at = -1;
        int bad = 0;
        logic [3:0] snap;
        btn_a = 4'b0110;
        while (m_run[0][1] != 3 && waited < 100) begin
            step();
            waited++;
            checks++;
            if (dut_v !== mdl_v) $display("FAIL midcount_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
        end
        checks++;
        if (m_run[0][1] != 3) $display("FAIL midcount_reach got %0d ticks need 3", m_run[0][1]);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 80 && q_at < 0; k++) begin
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL midcount_restart_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
            if (m_tick && m_samp[0][1]) q++;
            if (prs_a[1]) q_at = q;
        end
        checks++;
        if (q_at != ST) $display("FAIL midcount_ticks got %0d need %0d", q_at, ST);
        else passed++;

        tick_run = 1'b0;
        tick_clk = 1'b0;
        snap = lvl_a;
        repeat (50) begin
            btn_a = 4'($urandom);
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL freeze0_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
            if (lvl_a !== snap || prs_a != 0 || rel_a != 0) bad++;
        end
        tick_clk = 1'b1;
        step();
        snap = lvl_a;
        repeat (50) begin
            btn_a = 4'($urandom);
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL freeze1_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
            if (lvl_a !== snap || prs_a != 0 || rel_a != 0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL freeze_outputs got %0d changed cycles need 0", bad);
        else passed++;
        tick_run = 1'b1;
    endtask

    task automatic test_active_low();
        int npress = 0;
        rst = 1'b1;
        btn_a = 4'h0;
        btn_b = 4'hF;
        step();
        rst = 1'b0;
        repeat (60) begin
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL actlow_idle_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
        end
        checks++;
        if (lvl_b !== 4'h0) $display("FAIL actlow_idle_level got %b need 0000", lvl_b);
        else passed++;
        btn_b = 4'b0111;
        repeat (60) begin
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL actlow_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
            if (prs_b == 4'b1000) npress++;
        end
        checks++;
        if (npress != 1 || lvl_b !== 4'b1000)
            $display("FAIL actlow_press got presses=%0d level=%b need 1 and 1000", npress, lvl_b);
        else passed++;
    endtask

    task automatic test_random();
        repeat (3000) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 39) == 0) btn_a[c] = ~btn_a[c];
                if ($urandom_range(0, 39) == 0) btn_b[c] = ~btn_b[c];
            end
            rst = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if (dut_v !== mdl_v) $display("FAIL random_model t=%0t got %h need %h", $time, dut_v, mdl_v);
            else passed++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick_clk = 1'b0;
        btn_a = 4'h0;
        btn_b = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_midcount_and_freeze();
        test_active_low();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/debounce_module.md
# debounce_module

Multi-channel push-button debouncer that consumes the slow sample clock produced by the clock divider (typically a 1 kHz square wave) and turns raw, bouncing board buttons into clean levels plus single-cycle press/release pulses. All logic runs in the `clkin` domain. The sample clock is used only as a sampling strobe, via rising-edge detection, and never as a clock. It sits between the board button pins and every control consumer (reset buttons, keyboard/step controls, mode switches).

## Interface
- `WIDTH`, 4: number of button channels.
- `STABLE_TICKS`, 10: consecutive sample ticks a new value must persist before it is accepted; legal range ≥1. At 1 kHz, 10 = 10 ms.
- `ACTIVE_LOW`, 0: 1 = pressed button reads 0 on the pin; it is inverted after synchronisation.
- `clkin`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, synchronous, active-high.
- `tick_clk`  in  1  divided sample clock from the clock divider; already a `clkin`-registered signal, so it needs no synchroniser.
- `btn_in`  in  WIDTH  raw asynchronous button pins.
- `btn_level`  out  WIDTH  debounced state, 1 = pressed.
- `btn_press`  out  WIDTH  one-`clkin`-cycle pulse on each debounced 0→1.
- `btn_release`  out  WIDTH  one-`clkin`-cycle pulse on each debounced 1→0.

## Operation
- **Synchroniser:** two flops per channel on `btn_in`. Reset value is the pin's inactive level (`ACTIVE_LOW` ? 1 : 0). Polarity is applied after the second flop, giving `samp[i]`.
- **Tick:** `tick_d` is a register of `tick_clk`, reset 0, and `tick = tick_clk & ~tick_d`. If `tick_clk` is already 1 when `rst` drops, exactly one tick fires on the first cycle.
- **Per channel, only in tick cycles:**
  - If `samp[i]` equals `btn_level[i]`, then `cnt[i]` is cleared to 0.
  - Otherwise, if `cnt[i]+1 == STABLE_TICKS`, then `btn_level[i]` takes `samp[i]`, `cnt[i]` is cleared to 0, and the matching press or release pulse is raised.
  - Otherwise `cnt[i]` increments.
- **Non-tick cycles:** `cnt`, `btn_level` are held; pulses are 0.
- **Counter width:** `cnt` is `$clog2(STABLE_TICKS+1)` bits and never wraps, because it clears at `STABLE_TICKS-1`.
- **Bounce:** any tick that sees `samp[i] == btn_level[i]` restarts that channel's count.
- **Channel independence:** channels are fully independent. Simultaneous events on different channels produce pulses in the same cycle. `btn_press` and `btn_release` are never both high on the same channel.
- **Reset (any time, including mid-count):** all outputs 0, all `cnt` 0, synchronisers at inactive. No pulse is generated by reset itself or in the first cycle after reset.

## Timing
- Reset values: `btn_level` = 0, `btn_press` = 0, `btn_release` = 0.
- Pin-to-`samp` latency: 2 `clkin` cycles.
- Acceptance is counted in ticks: the change is accepted on the `STABLE_TICKS`-th consecutive tick that sees the new `samp`.
- `btn_level` and the pulse are registered and change together, one `clkin` cycle after the accepting tick cycle.
- `STABLE_TICKS=1`: the level follows `samp` on the next tick, with no filtering.
- `tick_clk` stuck at 0 or stuck at 1: outputs frozen, no pulses.
- `btn_press` and `btn_release` are exactly one `clkin` cycle wide, independent of the tick rate.

## Structure
- No shared package is needed. The only constant is the derived counter width, computed locally.
- Sub-module `debounce_channel`: one channel's count/level/pulse logic, with inputs `clkin`, `rst`, `tick`, `samp` and outputs `level`, `press`, `release`. It is instantiated WIDTH times with a generate loop.
- The synchronisers, polarity inversion and tick edge detector live in the top level and are shared by all channels.

## Test plan
All scenarios use WIDTH=4, STABLE_TICKS=4, ACTIVE_LOW=0, and `tick_clk` with a 10-cycle period (5 cycles high, 5 low).

1. **Reset:** assert `rst` for 3 cycles with `btn_in`=4'b1111 → all outputs 0 during reset. `btn_level` becomes 4'b1111 on the 4th tick after release, with `btn_press`=4'b1111 for 1 cycle.
2. **Clean press:** `btn_in[0]` 0→1 and held → `btn_level[0]` rises 1 cycle after the 4th tick that sees `samp[0]`=1. `btn_press`=4'b0001 for exactly 1 cycle. `btn_release` stays 0.
3. **Bounce:** `btn_in[1]` alternates every tick for 6 ticks, then holds 1 → no level change and no pulse during the alternation. Acceptance occurs exactly 4 ticks after the hold begins.
4. **Simultaneous events:** `btn_level`=4'b0001, then `btn_in` changes to 4'b0100 in a single cycle → in the same cycle, `btn_press`=4'b0100 and `btn_release`=4'b0001. `btn_level` ends at 4'b0100.
5. **Reset mid-count and frozen tick:**
   - Assert `rst` for 1 cycle after 3 qualifying ticks → the count restarts and 4 further ticks are required.
   - Hold `tick_clk`=0 and toggle `btn_in` → outputs stay unchanged.
6. **Active-low:** ACTIVE_LOW=1, `btn_in` held 4'b1111 → `btn_level`=0. Drive `btn_in[3]`=0 → `btn_press`=4'b1000 after 4 ticks.
